// File: rtl/imem_loader_if.sv
// Handshake and instruction-memory bundle for imem_loader.
// The host drives start/len and the byte stream; the loader drives everything else.
interface imem_loader_if #(
  parameter int IMEM_DEPTH = 256
) ();
  localparam int ADDR_W = $clog2(IMEM_DEPTH);

  logic              start;
  logic [ADDR_W:0]   len;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_run;
  logic              busy;
  logic              error;

  modport master (
    output start, len, s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata, core_run, busy, error
  );

  modport slave (
    input  start, len, s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata, core_run, busy, error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words, writes them from word 0 up,
// then releases the core. Define IMEM_LOADER_CHECKSUM_EN to require a trailing 32-bit sum.
module imem_loader #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  imem_loader_if.slave  bus_io
);
  localparam int ADDR_W = $clog2(IMEM_DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(IMEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   wordCnt_q, wordCnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [1:0]        byteCnt_q, byteCnt_d;
  logic [23:0]       shift_q, shift_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              run_q, run_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

  logic        fire;
  logic        wordDone;
  logic [31:0] word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus_io.s_ready = (state_q == LOAD) || (state_q == CHECK);
`else
  assign bus_io.s_ready = (state_q == LOAD);
`endif

  assign fire       = bus_io.s_valid && bus_io.s_ready;
  assign wordDone   = fire && (byteCnt_q == 2'd3);
  assign word       = {shift_q, bus_io.s_data};

  assign bus_io.busy       = bus_io.s_ready;
  assign bus_io.error      = (state_q == ERROR);
  assign bus_io.core_run   = run_q;
  assign bus_io.imem_we    = we_q;
  assign bus_io.imem_addr  = addr_q;
  assign bus_io.imem_wdata = wdata_q;

  always_comb begin
    state_d   = state_q;
    wordCnt_d = wordCnt_q;
    len_d     = len_q;
    byteCnt_d = byteCnt_q;
    shift_d   = shift_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    run_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    // Byte assembly is shared by word loading and checksum reception.
    if (fire) begin
      byteCnt_d = byteCnt_q + 2'd1;
      shift_d   = {shift_q[15:0], bus_io.s_data};
    end

    case (state_q)
      IDLE, DONE, ERROR: begin
        run_d = (state_q == DONE);
        if (bus_io.start) begin
          run_d     = 1'b0;
          len_d     = bus_io.len;
          wordCnt_d = '0;
          byteCnt_d = '0;
          shift_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d     = '0;
`endif
          if (bus_io.len > DEPTH_L) begin
            state_d = ERROR;
          end else if (bus_io.len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
            run_d   = 1'b1;
`endif
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (wordDone) begin
          we_d      = 1'b1;
          addr_d    = wordCnt_q[ADDR_W-1:0];
          wdata_d   = word;
          wordCnt_d = wordCnt_q + (ADDR_W+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d     = sum_q + word;
          if (wordCnt_d == len_q) state_d = CHECK;
`else
          if (wordCnt_d == len_q) state_d = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (wordDone) state_d = (word == sum_q) ? DONE : ERROR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wordCnt_q <= '0;
      len_q     <= '0;
      byteCnt_q <= '0;
      shift_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      run_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wordCnt_q <= wordCnt_d;
      len_q     <= len_d;
      byteCnt_q <= byteCnt_d;
      shift_q   <= shift_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      run_q     <= run_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed boot sequences, a start-decision table
// and randomized loads compared against a byte-stream-to-word model.
module tb_imem_loader;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.IMEM_DEPTH(DEPTH)) bus ();
  imem_loader #(.IMEM_DEPTH(DEPTH)) dut (.clk_i(clk), .rst_ni(rst_n), .bus_io(bus));

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;
  int startCyc;
  int runRiseCyc = -1;
  logic prevRun  = 1'b0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            wcyc;
  } wr_t;

  typedef struct {
    int   len;
    logic expBusy;
    logic expErr;
    logic expRun;
  } vec_t;

  wr_t        wrQ[$];
  logic [7:0] streamQ[$];
  int         acceptCyc[$];
  vec_t       vecs[8];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the memory port and core release mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    if (bus.imem_we) wrQ.push_back('{bus.imem_addr, bus.imem_wdata, cyc});
    if (bus.core_run && !prevRun) runRiseCyc <= cyc;
    prevRun <= bus.core_run;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic checkStatus(input string tag, input logic expBusy, input logic expErr,
                             input logic expRun);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'(expBusy));
    checkOutput({tag, "_ready"}, 32'(bus.s_ready), 32'(expBusy));
    checkOutput({tag, "_error"}, 32'(bus.error), 32'(expErr));
    checkOutput({tag, "_run"}, 32'(bus.core_run), 32'(expRun));
  endtask

  task automatic checkResetOuts(input string tag);
    checkStatus(tag, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_we"}, 32'(bus.imem_we), 32'd0);
    checkOutput({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
    checkOutput({tag, "_wdata"}, bus.imem_wdata, 32'd0);
  endtask

  task automatic doStart(input int n);
    bus.start = 1'b1;
    bus.len   = n[AW:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    startCyc  = cyc;
  endtask

  task automatic fillRandom(input int n);
    streamQ.delete();
    for (int i = 0; i < 4 * n; i++) streamQ.push_back(8'($urandom_range(0, 255)));
  endtask

  // Streams streamQ, inserting an optional fixed gap, random gaps and a stray start pulse.
  task automatic applyStimulus(input int gapAt, input int gapLen, input bit randGaps,
                               input int pulseAt);
    bit ok;
    bit rdy;
    int budget;
    acceptCyc.delete();
    for (int i = 0; i < streamQ.size(); i++) begin
      if (i == gapAt) begin
        bus.s_valid = 1'b0;
        repeat (gapLen) begin @(posedge clk); #1; end
      end
      if (randGaps && $urandom_range(0, 3) == 0) begin
        bus.s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      if (i == pulseAt) begin
        bus.start = 1'b1;
        bus.len   = (AW+1)'(1);
      end
      bus.s_valid = 1'b1;
      bus.s_data  = streamQ[i];
      ok = 1'b0;
      budget = 0;
      while (!ok && budget < 20) begin
        @(negedge clk);
        rdy = bus.s_ready;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ok = rdy;
        budget++;
      end
      if (!ok) begin
        checkOutput("s_ready_timeout", 32'(ok), 32'd1);
        break;
      end
      acceptCyc.push_back(cyc);
    end
    bus.s_valid = 1'b0;
  endtask

  // streamQ holds 4*n data bytes; the model derives the words and the expected writes.
  task automatic runLoad(input int n, input int gapAt, input int gapLen, input bit randGaps,
                         input int pulseAt, input string tag);
    logic [31:0] expW[$];
    logic [31:0] sum;
    int base;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      expW.push_back({streamQ[4*i], streamQ[4*i+1], streamQ[4*i+2], streamQ[4*i+3]});
      sum += expW[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    streamQ.push_back(sum[31:24]);
    streamQ.push_back(sum[23:16]);
    streamQ.push_back(sum[15:8]);
    streamQ.push_back(sum[7:0]);
`endif
    base = wrQ.size();
    applyStimulus(gapAt, gapLen, randGaps, pulseAt);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({tag, "_wrcount"}, 32'(wrQ.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < wrQ.size() && 4*i+3 < acceptCyc.size()) begin
        checkOutput($sformatf("%s_addr%0d", tag, i), 32'(wrQ[base+i].addr), 32'(i));
        checkOutput($sformatf("%s_data%0d", tag, i), wrQ[base+i].data, expW[i]);
        checkOutput($sformatf("%s_wcyc%0d", tag, i), 32'(wrQ[base+i].wcyc),
                    32'(acceptCyc[4*i+3]));
      end
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (acceptCyc.size() == 4 * n)
      checkOutput({tag, "_runrise"}, 32'(runRiseCyc), 32'(acceptCyc[4*n-1] + 1));
`endif
    checkStatus({tag, "_end"}, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int n;
    bus.start   = 1'b0;
    bus.len     = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    vecs[0] = '{17, 1'b0, 1'b1, 1'b0};
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs[1] = '{0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{0, 1'b1, 1'b0, 1'b0};
`else
    vecs[1] = '{0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{0, 1'b0, 1'b0, 1'b1};
`endif
    vecs[2] = '{16, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{5, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{20, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{31, 1'b0, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    checkResetOuts("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkStatus("idle", 1'b0, 1'b0, 1'b0);

    $display("[TB] back-to-back two-word load");
    doStart(2);
    checkStatus("t2_start", 1'b1, 1'b0, 1'b0);
    streamQ = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00, 8'h00};
    runLoad(2, -1, 0, 1'b0, -1, "t2");
    checkOutput("t2_first_accept", 32'(acceptCyc[0]), 32'(startCyc + 1));
    checkOutput("t2_span", 32'(acceptCyc[7] - acceptCyc[0]), 32'd7);
    checkOutput("t2_word0", wrQ[wrQ.size()-2].data, 32'h20080005);
    checkOutput("t2_word1", wrQ[wrQ.size()-1].data, 32'h08000000);

    $display("[TB] same load with a 3-cycle stall after byte 2");
    doStart(2);
    checkStatus("t3_start", 1'b1, 1'b0, 1'b0);
    streamQ = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00, 8'h00};
    runLoad(2, 2, 3, 1'b0, -1, "t3");
    checkOutput("t3_span", 32'(acceptCyc[7] - acceptCyc[0]), 32'd10);

    $display("[TB] oversize length then recovery");
    doStart(DEPTH + 1);
    checkStatus("t4_err", 1'b0, 1'b1, 1'b0);
    base = wrQ.size();
    bus.s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("t4_ready_held", 32'(bus.s_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    checkOutput("t4_nowrite", 32'(wrQ.size() - base), 32'd0);
    doStart(1);
    checkStatus("t4_restart", 1'b1, 1'b0, 1'b0);
    fillRandom(1);
    runLoad(1, -1, 0, 1'b0, -1, "t4");

    $display("[TB] reset in the middle of a load");
    doStart(2);
    fillRandom(2);
    streamQ = streamQ[0:4];
    applyStimulus(-1, 0, 1'b0, -1);
    #2 rst_n = 1'b0;
    #1 checkResetOuts("t5_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.s_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkStatus("t5_after", 1'b0, 1'b0, 1'b0);
    end
    bus.s_valid = 1'b0;
    doStart(2);
    fillRandom(2);
    runLoad(2, -1, 0, 1'b1, -1, "t5");

    $display("[TB] start pulse ignored during load");
    doStart(3);
    fillRandom(3);
    runLoad(3, -1, 0, 1'b0, 6, "t6");

    $display("[TB] start decision table");
    for (int v = 0; v < 8; v++) begin
      doStart(vecs[v].len);
      checkStatus($sformatf("vec%0d", v), vecs[v].expBusy, vecs[v].expErr, vecs[v].expRun);
      if (vecs[v].expBusy) begin
        fillRandom(vecs[v].len);
        runLoad(vecs[v].len, -1, 0, 1'b1, -1, $sformatf("vec%0d", v));
      end
    end

    $display("[TB] randomized loads");
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, DEPTH);
      doStart(n);
      fillRandom(n);
      runLoad(n, -1, 0, 1'b1, -1, $sformatf("rnd%0d", k));
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    $display("[TB] checksum match and mismatch");
    doStart(1);
    streamQ = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    applyStimulus(-1, 0, 1'b0, -1);
    repeat (2) @(posedge clk);
    #1;
    checkStatus("ck_good", 1'b0, 1'b0, 1'b1);
    doStart(1);
    streamQ = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    applyStimulus(-1, 0, 1'b0, -1);
    repeat (2) @(posedge clk);
    #1;
    checkStatus("ck_bad", 1'b0, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader that sits directly upstream of the core's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words into consecutive instruction-memory locations starting at word 0. It holds the core in reset until the programmed word count has been written, then releases it so the PC starts fetching at address 0.

## Interface
Parameters:
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words; power of two, ≥ 4
- ADDR_W, $clog2(IMEM_DEPTH), word-address width (derived, not overridden)

Ports:
- clk  in  1  single clock; every register is updated on the rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load
- len  in  ADDR_W+1  number of words to load; sampled on the cycle start is accepted
- s_valid  in  1  byte stream valid
- s_data  in  8  byte stream data
- s_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction memory write strobe (one cycle per word)
- imem_addr  out  ADDR_W  instruction memory word address
- imem_wdata  out  32  instruction word
- core_run  out  1  high means the core may run; drive the core's active-low reset from this
- busy  out  1  load in progress
- error  out  1  sticky load error, cleared by the next accepted start

## Operation
- States:
  - IDLE: entered from reset.
  - LOAD: receives words.
  - CHECK: present only with the checksum feature.
  - DONE
  - ERROR
- IDLE/DONE/ERROR, start=1:
  - len > IMEM_DEPTH → ERROR, error=1.
  - len == 0 → DONE.
  - Otherwise → LOAD. On entry: word counter=0, byte counter=0, core_run=0, error=0.
- start while in LOAD or CHECK is ignored.
- LOAD:
  - s_ready=1.
  - A byte transfers when s_valid & s_ready.
  - Byte k of a word (k=0..3) goes to bits [31-8k -: 8]. The first byte is the MSB, matching the MIPS big-endian instruction layout.
  - After byte 3:
    - imem_wdata = assembled word.
    - imem_addr = word counter.
    - imem_we pulses.
    - Word counter increments.
  - When the word counter reaches len, LOAD exits (to CHECK, or to DONE without the feature).
- s_valid low stalls without penalty. The byte counter holds, and partial words are retained indefinitely.
- DONE: core_run=1, s_ready=0, busy=0.
- ERROR: core_run=0, s_ready=0, error=1.
- busy=1 exactly in LOAD and CHECK.
- Bytes presented outside LOAD/CHECK are not accepted (s_ready=0).
- len == IMEM_DEPTH is legal. The word counter is ADDR_W+1 bits wide, so the last address written is IMEM_DEPTH-1 and nothing wraps.

## Timing
- Reset values: state=IDLE, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_run=0, busy=0, error=0, all counters 0.
- Reset mid-load aborts immediately. Instruction-memory contents already written are undefined for the next boot.
- imem_we/imem_addr/imem_wdata are registered: the write strobe is asserted on the cycle after the 4th byte handshake.
- Maximum throughput: one byte per cycle. Consecutive words therefore produce imem_we every 4th cycle.
- Minimum load latency is 4·len cycles from the first byte accepted to the last imem_we.
- core_run is registered:
  - It rises the cycle after the last imem_we, or one cycle after the accepted start when len==0.
  - It falls the cycle after a start is accepted in DONE.
- The state moves out of IDLE/DONE/ERROR on the edge where start is sampled. s_ready is high from the following cycle.

## Configuration
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word, LOAD enters CHECK, which accepts 4 further bytes (big-endian) forming a 32-bit checksum.
  - Expected value: sum of all loaded words mod 2^32, accumulated as each word is written.
  - Match → DONE. Mismatch → ERROR, core_run stays 0.
  - len==0 with the feature: CHECK still runs, and the expected sum is 0.
  - Checksum bytes are never written to instruction memory.
- Undefined: there is no CHECK state and no accumulator. LOAD goes straight to DONE after the last word.

## Test plan
- len=2, bytes 20 08 00 05 / 08 00 00 00 streamed back-to-back → imem_we at addr 0 data 0x20080005, then addr 1 data 0x08000000; core_run=1 one cycle after the second write; busy=0.
- Same stream with s_valid deasserted for 3 cycles after byte 2 → identical writes and data, delayed by 3 cycles; no extra imem_we.
- start with len=IMEM_DEPTH+1 → error=1 and core_run=0 the next cycle, s_ready stays 0; a following start with len=1 clears error and loads normally.
- rst asserted after 5 of 8 bytes → all outputs at reset values asynchronously; after release, state IDLE and core_run=0 until a new complete load.
- start pulsed during LOAD (len=3 in progress) → ignored; all 3 words are written to addrs 0..2.
- With IMEM_LOADER_CHECKSUM_EN, len=1, word 0x00000001:
  - Checksum 00 00 00 01 → DONE, core_run=1.
  - Checksum 00 00 00 02 → ERROR, error=1, core_run=0.
